bk_sub_pipe_16b: RTL and testbench

- Pipelined, handshaked 16-bit unsigned/two's-complement subtractor built on a Brent-Kung prefix carry tree. It is the inverse-direction companion of the team's Brent-Kung adder.
- Computes D = X - Y as X + ~Y + 1 and reports borrow, zero and signed overflow.
- Sits in datapaths that need registered subtraction with valid/ready flow control, e.g. error terms in ALS benchmark harnesses.

---
 rtl/bk_pkg.sv | 27 ++
 rtl/bk_sub_pcell.sv | 13 +
 rtl/bk_sub_pipe_16b.sv | 139 +++++++++++++
 tb/tb_bk_sub_pipe_16b.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared Brent-Kung prefix types and helpers: generate/propagate pair, carry operator, log2.
// Used by the pipelined subtractor and its prefix cells; no state, no latency.
package bk_pkg;

  localparam int WIDTH_DEF = 16;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

  // (G,P) o (G',P'): hi is the more significant span, lo the adjacent lower one
  function automatic gp_t gp_op(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_sub_pcell.sv
// Single Brent-Kung prefix cell merging two adjacent (g,p) spans.
// Purely combinational: zero latency, no flow control of its own.
module bk_sub_pcell
  import bk_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o = gp_op(hi, lo);

endmodule

// File: rtl/bk_sub_pipe_16b.sv
// Pipelined Brent-Kung subtractor D = X - Y with borrow/zero/ovf; 3 register stages, 1 result/cycle.
// Valid/ready backpressure: stages compact over bubbles and the full pipe holds while out_ready=0.
module bk_sub_pipe_16b
  import bk_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int LEVELS = clog2(WIDTH);

  logic             v1, v2, v3;
  logic             en1, en2, en3;
  logic [WIDTH-1:0] s1_g, s1_p;
  logic             s1_xs, s1_ys;
  logic [WIDTH-1:0] s2_g, s2_p, s2_p0;
  logic             s2_xs, s2_ys;
  logic [WIDTH-1:0] up_g, up_p;
  logic [WIDTH-1:0] pre_g, pre_p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  // Each stage may load when it is empty or its contents move on this cycle
  assign en3       = ~v3 | out_ready;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // Up-sweep: level l merges spans of 2^l ending at bits i = k*2^l - 1
  for (genvar l = 0; l <= LEVELS; l++) begin : g_up
    gp_t row [WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (l == 0) begin : g_leaf
        assign row[i] = {s1_g[i], s1_p[i]};
      end else if ((i + 1) % (1 << l) == 0) begin : g_cell
        bk_sub_pcell u_cell (
          .hi(g_up[l-1].row[i]),
          .lo(g_up[l-1].row[i - (1 << (l - 1))]),
          .o (row[i])
        );
      end else begin : g_pass
        assign row[i] = g_up[l-1].row[i];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_up_out
    assign up_g[i] = g_up[LEVELS].row[i].g;
    assign up_p[i] = g_up[LEVELS].row[i].p;
  end

  // Down-sweep: fill the half-span positions, ending with the odd/even level
  for (genvar j = 0; j < LEVELS; j++) begin : g_dn
    gp_t row [WIDTH];
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (j == 0) begin : g_leaf
        assign row[i] = {s2_g[i], s2_p[i]};
      end else if ((i >= (1 << (LEVELS - j))) &&
                   ((i + 1) % (1 << (LEVELS - j)) == (1 << (LEVELS - j - 1)))) begin : g_cell
        bk_sub_pcell u_cell (
          .hi(g_dn[j-1].row[i]),
          .lo(g_dn[j-1].row[i - (1 << (LEVELS - j - 1))]),
          .o (row[i])
        );
      end else begin : g_pass
        assign row[i] = g_dn[j-1].row[i];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_dn_out
    assign pre_g[i] = g_dn[LEVELS-1].row[i].g;
    assign pre_p[i] = g_dn[LEVELS-1].row[i].p;
  end

  // Carry-in of 1 turns X + ~Y into X - Y
  assign c[0]       = 1'b1;
  assign c[WIDTH:1] = pre_g | pre_p;
  assign sum        = s2_p0 ^ c[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_g   <= '0;
      s1_p   <= '0;
      s1_xs  <= 1'b0;
      s1_ys  <= 1'b0;
      s2_g   <= '0;
      s2_p   <= '0;
      s2_p0  <= '0;
      s2_xs  <= 1'b0;
      s2_ys  <= 1'b0;
      D      <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en1 && in_valid) begin
        s1_g  <= X & ~Y;
        s1_p  <= X ^ ~Y;
        s1_xs <= X[WIDTH-1];
        s1_ys <= Y[WIDTH-1];
      end
      if (en2 && v1) begin
        s2_g  <= up_g;
        s2_p  <= up_p;
        s2_p0 <= s1_p;
        s2_xs <= s1_xs;
        s2_ys <= s1_ys;
      end
      // Result fields only change when a new result lands, so they hold across bubbles
      if (en3 && v2) begin
        D      <= sum;
        borrow <= ~c[WIDTH];
        zero   <= ~|sum;
        ovf    <= (s2_xs ^ s2_ys) & (sum[WIDTH-1] ^ s2_xs);
      end
    end
  end

endmodule

// File: tb/tb_bk_sub_pipe_16b.sv
// Bench for bk_sub_pipe_16b: directed scenarios plus a queue scoreboard fed on every accepted input.
module tb_bk_sub_pipe_16b;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         borrow;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  logic [W+2:0] sb [$];
  logic [W+2:0] sb_exp;
  logic [W+2:0] sb_got;

  bk_sub_pipe_16b dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (D),
    .borrow   (borrow),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Reference: 17-bit unsigned difference for D/borrow, integer signed range for overflow
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] full;
    int         sd;
    logic       o;
    full = {1'b0, x} - {1'b0, y};
    sd   = int'($signed(x)) - int'($signed(y));
    o    = (sd > 32767) || (sd < -32768);
    return {full[W-1:0], full[W], (full[W-1:0] == 16'h0000), o};
  endfunction

  // Handshakes are sampled on the falling edge and complete on the following rising edge
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got D=%h b=%b z=%b o=%b with empty queue", D, borrow, zero, ovf);
        end else begin
          sb_exp = sb.pop_front();
          sb_got = {D, borrow, zero, ovf};
          if (sb_got !== sb_exp) begin
            errors++;
            $display("FAIL sb_result got D=%h b=%b z=%b o=%b need D=%h b=%b z=%b o=%b",
                     sb_got[W+2:3], sb_got[2], sb_got[1], sb_got[0],
                     sb_exp[W+2:3], sb_exp[2], sb_exp[1], sb_exp[0]);
          end
        end
        pops++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(X, Y));
        pushes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and return just after the edge that accepts it
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    logic ok;
    ok       = 1'b0;
    X        = x;
    Y        = y;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, D, borrow, zero, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b D=%h b=%b z=%b o=%b required all 0",
               out_valid, D, borrow, zero, ovf);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] tx [5];
    logic [W-1:0] ty [5];
    logic [W+2:0] te [5];
    int           lat;
    logic         seen;
    tx = '{16'h0005, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF};
    ty = '{16'h0003, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF};
    te = '{{16'h0002, 1'b0, 1'b0, 1'b0},
           {16'hFFFF, 1'b1, 1'b0, 1'b0},
           {16'h0000, 1'b0, 1'b1, 1'b0},
           {16'h7FFF, 1'b0, 1'b0, 1'b1},
           {16'h8000, 1'b1, 1'b0, 1'b1}};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(tx[k], ty[k]);
      lat  = 1;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        tick();
        lat++;
      end
      checks++;
      if (!seen || lat != 3) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d edges (seen=%b) required 3", k, lat, seen);
      end
      checks++;
      if ({D, borrow, zero, ovf} !== te[k]) begin
        errors++;
        $display("FAIL basic_result[%0d] got D=%h b=%b z=%b o=%b required D=%h b=%b z=%b o=%b",
                 k, D, borrow, zero, ovf, te[k][W+2:3], te[k][2], te[k][1], te[k][0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int           nxt;
    int           acc;
    int           recv;
    int           gaps;
    logic         flowing;
    logic         stable;
    logic [W-1:0] held;
    nxt     = 1;
    acc     = 0;
    recv    = 0;
    gaps    = 0;
    flowing = 1'b0;
    stable  = 1'b1;
    held    = '0;
    for (int c = 0; c < 60 && recv < 6; c++) begin
      out_ready = (c < 2) || (c >= 8);
      if (nxt <= 6) begin
        in_valid = 1'b1;
        X        = 16'(nxt);
        Y        = 16'(2 * nxt);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc++;
        nxt++;
      end
      if (c == 3) held = D;
      if (c > 3 && c < 8 && (D !== held || out_valid !== 1'b1 || in_ready !== 1'b0)) stable = 1'b0;
      if (c == 7) begin
        checks++;
        if (acc != 3) begin
          errors++;
          $display("FAIL bp_accepts got %0d accepted while stalled required 3", acc);
        end
        checks++;
        if (held !== 16'hFFFF) begin
          errors++;
          $display("FAIL bp_held_value got D=%h required FFFF", held);
        end
      end
      if (flowing && !out_valid) gaps++;
      if (out_valid && out_ready) begin
        recv++;
        flowing = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_stall_stable got outputs/in_ready changing during stall required held");
    end
    checks++;
    if (recv != 6 || gaps != 0) begin
      errors++;
      $display("FAIL bp_drain got %0d results with %0d gaps required 6 with 0", recv, gaps);
    end
  endtask

  task automatic test_random();
    int   sent;
    int   cyc;
    logic acc;
    sent     = 0;
    cyc      = 0;
    acc      = 1'b0;
    in_valid = 1'b0;
    while (sent < 10000 && cyc < 60000) begin
      if (acc) sent++;
      if (!in_valid || acc) begin
        if (sent < 10000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          X = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
          Y = ($urandom_range(0, 7) == 0) ? X : 16'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
    checks++;
    if (sent != 10000) begin
      errors++;
      $display("FAIL rand_sent got %0d accepted required 10000", sent);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rand_drain got %0d results outstanding required 0", sb.size());
    end
  endtask

  task automatic test_reset_flush();
    int   stale;
    int   lat;
    logic seen;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(16'(k + 1), 16'h0000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_inflight got out_valid=%b required 1", out_valid);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || D !== 16'h0000) begin
      errors++;
      $display("FAIL flush_async got out_valid=%b D=%h required 0/0000", out_valid, D);
    end
    sb.delete();
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL flush_stale got %0d stale results required 0", stale);
    end
    send(16'h0010, 16'h0001);
    lat  = 1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    checks++;
    if (!seen || lat != 3 || D !== 16'h000F) begin
      errors++;
      $display("FAIL flush_after got D=%h latency %0d (seen=%b) required 000F latency 3", D, lat, seen);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_flush();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got no completion required finish within 3ms sim time");
    $fatal(1, "watchdog");
  end

endmodule
